rng_word_collector: RTL and testbench

//   Consumer end of the NeoRNG byte stream. Drives the RNG enable and accepts valid/data bytes.

---
 rtl/rng_pkg.sv | 19 +
 rtl/rng_sync_fifo.sv | 58 +++++
 rtl/rng_word_collector.sv | 142 ++++++++++++++
 tb/tb_rng_word_collector.sv | 225 ++++++++++++++++++++++
 4 files changed

// File: rtl/rng_pkg.sv
// Shared state encodings and helpers for the RNG word collector.
package rng_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_FAIL = 2'd2
    } state_t;

    function automatic int unsigned clog2(input int unsigned value);
        int unsigned r;
        r = 0;
        for (int unsigned i = 0; i < 32; i++) begin
            if ((64'd1 << i) < 64'(value)) r = i + 1;
        end
        return r;
    endfunction

endpackage

// File: rtl/rng_sync_fifo.sv
// Synchronous FIFO with register-array storage, flush, and push/pop while full.
module rng_sync_fifo
    import rng_pkg::*;
#(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned DEPTH = 8
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      push,
    input  logic                      pop,
    input  logic                      flush,
    input  logic [WIDTH-1:0]          din,
    output logic [WIDTH-1:0]          dout,
    output logic                      empty,
    output logic                      full,
    output logic [clog2(DEPTH):0]     level
);

    localparam int unsigned AW = clog2(DEPTH);
    localparam int unsigned LW = AW + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [LW-1:0]    count;
    logic             do_push;
    logic             do_pop;

    assign empty   = (count == '0);
    assign full    = (count == LW'(DEPTH));
    assign level   = count;
    assign dout    = mem[rd_ptr];
    assign do_pop  = pop && !empty;
    // A full FIFO still accepts a push when the head leaves in the same cycle.
    assign do_push = push && (!full || do_pop);

    always_ff @(posedge clk) begin
        if (!rst) begin
            for (int unsigned i = 0; i < DEPTH; i++) mem[i] <= '0;
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                mem[wr_ptr] <= din;
                wr_ptr      <= wr_ptr + AW'(1);
            end
            if (do_pop) rd_ptr <= rd_ptr + AW'(1);
            count <= count + LW'(do_push) - LW'(do_pop);
        end
    end

endmodule

// File: rtl/rng_word_collector.sv
// Collects RNG bytes into words, buffers them and stops on a stuck source.
module rng_word_collector
    import rng_pkg::*;
#(
    parameter int unsigned BYTES_PER_WORD = 4,
    parameter int unsigned FIFO_DEPTH     = 8,
    parameter int unsigned REP_LIMIT      = 16
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          start_i,
    input  logic                          clear_i,
    output logic                          rng_enable_o,
    input  logic                          rng_valid_i,
    input  logic [7:0]                    rng_data_i,
    output logic [8*BYTES_PER_WORD-1:0]   word_o,
    output logic                          word_valid_o,
    input  logic                          word_ready_i,
    output logic [clog2(FIFO_DEPTH):0]    fifo_level_o,
    output logic                          overflow_o,
    output logic                          health_fail_o
);

    localparam int unsigned WORD_W = 8 * BYTES_PER_WORD;
    localparam int unsigned LW     = clog2(FIFO_DEPTH) + 1;
    localparam int unsigned CW     = clog2(BYTES_PER_WORD + 1);

    state_t            state;
    logic [WORD_W-1:0] pack;
    logic [WORD_W-1:0] word_next;
    logic [WORD_W-1:0] push_word;
    logic [CW-1:0]     byte_cnt;
    logic [7:0]        prev_byte;
    logic [7:0]        rep_cnt;
    logic [7:0]        rep_next;
    logic              push_q;
    logic              overflow;
    logic              health_fail;
    logic              accept;
    logic              trip;
    logic              word_done;
    logic              ovf_set;
    logic              fifo_empty;
    logic              fifo_full;

    assign accept    = (state == ST_RUN) && start_i && rng_valid_i;
    // rep_cnt == 0 marks "no previous byte since IDLE".
    assign rep_next  = (rep_cnt != 8'd0 && rng_data_i == prev_byte)
                     ? ((rep_cnt == 8'hFF) ? rep_cnt : rep_cnt + 8'd1) : 8'd1;
    assign trip      = accept && (rep_next == 8'(REP_LIMIT));
    assign word_done = accept && !trip && (byte_cnt == CW'(BYTES_PER_WORD - 1));
    assign ovf_set   = push_q && fifo_full && !(word_valid_o && word_ready_i) && !trip;

    assign word_valid_o  = !fifo_empty;
    assign rng_enable_o  = (state == ST_RUN) && (fifo_level_o < LW'(FIFO_DEPTH - 1));
    assign overflow_o    = overflow;
    assign health_fail_o = health_fail;

    always_comb begin
        word_next = pack;
        for (int unsigned k = 0; k < BYTES_PER_WORD; k++) begin
            if (byte_cnt == CW'(k)) word_next[8*k +: 8] = rng_data_i;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state       <= ST_IDLE;
            pack        <= '0;
            push_word   <= '0;
            byte_cnt    <= '0;
            prev_byte   <= '0;
            rep_cnt     <= '0;
            push_q      <= 1'b0;
            overflow    <= 1'b0;
            health_fail <= 1'b0;
        end else begin
            push_q <= 1'b0;
            if (clear_i)      overflow <= 1'b0;
            else if (ovf_set) overflow <= 1'b1;

            unique case (state)
                ST_IDLE: begin
                    rep_cnt  <= '0;
                    byte_cnt <= '0;
                    pack     <= '0;
                    if (start_i && !clear_i) state <= ST_RUN;
                end
                ST_RUN: begin
                    if (!start_i) begin
                        state    <= ST_IDLE;
                        byte_cnt <= '0;
                        pack     <= '0;
                    end else if (trip) begin
                        state       <= ST_FAIL;
                        health_fail <= 1'b1;
                        rep_cnt     <= rep_next;
                        byte_cnt    <= '0;
                        pack        <= '0;
                    end else if (accept) begin
                        rep_cnt   <= rep_next;
                        prev_byte <= rng_data_i;
                        if (word_done) begin
                            push_q    <= 1'b1;
                            push_word <= word_next;
                            byte_cnt  <= '0;
                            pack      <= '0;
                        end else begin
                            pack     <= word_next;
                            byte_cnt <= byte_cnt + CW'(1);
                        end
                    end
                end
                ST_FAIL: begin
                    if (clear_i) begin
                        state       <= ST_IDLE;
                        health_fail <= 1'b0;
                        rep_cnt     <= '0;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    rng_sync_fifo #(
        .WIDTH (WORD_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (push_q),
        .pop   (word_ready_i),
        .flush (trip),
        .din   (push_word),
        .dout  (word_o),
        .empty (fifo_empty),
        .full  (fifo_full),
        .level (fifo_level_o)
    );

endmodule

// File: tb/tb_rng_word_collector.sv
// Directed bench for rng_word_collector: vector table plus multi-cycle sequences.
module tb_rng_word_collector;

    logic        clk = 1'b0;
    logic        rst;
    logic        start_i;
    logic        clear_i;
    logic        rng_enable_o;
    logic        rng_valid_i;
    logic [7:0]  rng_data_i;
    logic [31:0] word_o;
    logic        word_valid_o;
    logic        word_ready_i;
    logic [3:0]  fifo_level_o;
    logic        overflow_o;
    logic        health_fail_o;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    rng_word_collector #(
        .BYTES_PER_WORD (4),
        .FIFO_DEPTH     (8),
        .REP_LIMIT      (16)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .start_i       (start_i),
        .clear_i       (clear_i),
        .rng_enable_o  (rng_enable_o),
        .rng_valid_i   (rng_valid_i),
        .rng_data_i    (rng_data_i),
        .word_o        (word_o),
        .word_valid_o  (word_valid_o),
        .word_ready_i  (word_ready_i),
        .fifo_level_o  (fifo_level_o),
        .overflow_o    (overflow_o),
        .health_fail_o (health_fail_o)
    );

    typedef struct {
        logic        start;
        logic        clear;
        logic        valid;
        logic [7:0]  data;
        logic        ready;
        logic        en;
        logic        wv;
        logic [31:0] word;
        logic [3:0]  level;
        logic        ovf;
        logic        fail;
    } vec_t;

    vec_t vecs [18];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [7:0] b);
        rng_valid_i = 1'b1;
        rng_data_i  = b;
        tick();
        rng_valid_i = 1'b0;
    endtask

    task automatic check_flags(input string tag, input logic en, input logic wv,
                               input logic [3:0] lvl, input logic ovf, input logic fail);
        check({tag, ".enable"}, 32'(rng_enable_o), 32'(en));
        check({tag, ".valid"}, 32'(word_valid_o), 32'(wv));
        check({tag, ".level"}, 32'(fifo_level_o), 32'(lvl));
        check({tag, ".overflow"}, 32'(overflow_o), 32'(ovf));
        check({tag, ".fail"}, 32'(health_fail_o), 32'(fail));
    endtask

    logic [31:0] exp_words [7];
    logic [7:0]  bv;

    initial begin
        // start clear valid data ready | en wv word level ovf fail
        vecs[0]  = '{0, 0, 0, 8'h00, 0, 0, 0, 32'h0, 4'd0, 0, 0};
        vecs[1]  = '{1, 0, 0, 8'h00, 0, 1, 0, 32'h0, 4'd0, 0, 0};
        vecs[2]  = '{1, 0, 1, 8'h11, 1, 1, 0, 32'h0, 4'd0, 0, 0};
        vecs[3]  = '{1, 0, 1, 8'h22, 1, 1, 0, 32'h0, 4'd0, 0, 0};
        vecs[4]  = '{1, 0, 1, 8'h33, 1, 1, 0, 32'h0, 4'd0, 0, 0};
        vecs[5]  = '{1, 0, 1, 8'h44, 1, 1, 0, 32'h0, 4'd0, 0, 0};
        vecs[6]  = '{1, 0, 0, 8'h00, 1, 1, 1, 32'h44332211, 4'd1, 0, 0};
        vecs[7]  = '{1, 0, 0, 8'h00, 1, 1, 0, 32'h0, 4'd0, 0, 0};
        vecs[8]  = '{1, 0, 1, 8'h01, 0, 1, 0, 32'h0, 4'd0, 0, 0};
        vecs[9]  = '{1, 0, 1, 8'h02, 0, 1, 0, 32'h0, 4'd0, 0, 0};
        vecs[10] = '{0, 0, 0, 8'h00, 0, 0, 0, 32'h0, 4'd0, 0, 0};
        vecs[11] = '{1, 0, 0, 8'h00, 0, 1, 0, 32'h0, 4'd0, 0, 0};
        vecs[12] = '{1, 0, 1, 8'h03, 0, 1, 0, 32'h0, 4'd0, 0, 0};
        vecs[13] = '{1, 0, 1, 8'h04, 0, 1, 0, 32'h0, 4'd0, 0, 0};
        vecs[14] = '{1, 0, 1, 8'h05, 0, 1, 0, 32'h0, 4'd0, 0, 0};
        vecs[15] = '{1, 0, 1, 8'h06, 0, 1, 0, 32'h0, 4'd0, 0, 0};
        vecs[16] = '{1, 0, 0, 8'h00, 0, 1, 1, 32'h06050403, 4'd1, 0, 0};
        vecs[17] = '{1, 0, 0, 8'h00, 1, 1, 0, 32'h0, 4'd0, 0, 0};

        rst = 1'b0; start_i = 1'b0; clear_i = 1'b0;
        rng_valid_i = 1'b0; rng_data_i = 8'h00; word_ready_i = 1'b0;
        tick();
        tick();
        check_flags("reset", 0, 0, 4'd0, 0, 0);
        check("reset.word", word_o, 32'h0);
        rst = 1'b1;

        // Basic packing, pop, and stop-mid-word via the vector table.
        for (int i = 0; i < 18; i++) begin
            start_i      = vecs[i].start;
            clear_i      = vecs[i].clear;
            rng_valid_i  = vecs[i].valid;
            rng_data_i   = vecs[i].data;
            word_ready_i = vecs[i].ready;
            tick();
            check_flags($sformatf("vec%0d", i), vecs[i].en, vecs[i].wv, vecs[i].level,
                        vecs[i].ovf, vecs[i].fail);
            if (vecs[i].wv) check($sformatf("vec%0d.word", i), word_o, vecs[i].word);
        end
        rng_valid_i = 1'b0;
        word_ready_i = 1'b0;

        // 15 repeats stay below the limit; 5A then resets the run length.
        for (int i = 0; i < 15; i++) send(8'hA5);
        send(8'h5A);
        check("rep15.fail", 32'(health_fail_o), 32'd0);
        tick();
        check("rep15.level", 32'(fifo_level_o), 32'd4);
        for (int i = 0; i < 15; i++) send(8'hA5);
        check("rep_reset.fail", 32'(health_fail_o), 32'd0);
        check("rep_reset.level", 32'(fifo_level_o), 32'd7);
        check("rep_reset.enable", 32'(rng_enable_o), 32'd0);
        start_i = 1'b0;
        tick();
        exp_words[0] = 32'hA5A5A5A5; exp_words[1] = 32'hA5A5A5A5;
        exp_words[2] = 32'hA5A5A5A5; exp_words[3] = 32'h5AA5A5A5;
        exp_words[4] = 32'hA5A5A5A5; exp_words[5] = 32'hA5A5A5A5;
        exp_words[6] = 32'hA5A5A5A5;
        for (int i = 0; i < 7; i++) begin
            check($sformatf("drain%0d.valid", i), 32'(word_valid_o), 32'd1);
            check($sformatf("drain%0d.word", i), word_o, exp_words[i]);
            word_ready_i = 1'b1;
            tick();
            word_ready_i = 1'b0;
        end
        check_flags("drained", 0, 0, 4'd0, 0, 0);

        // Fill to full, watch the enable margin, then force overflow.
        start_i = 1'b1;
        tick();
        bv = 8'h01;
        for (int i = 0; i < 24; i++) begin send(bv); bv++; end
        tick();
        check_flags("lvl6", 1, 1, 4'd6, 0, 0);
        for (int i = 0; i < 4; i++) begin send(bv); bv++; end
        tick();
        check_flags("lvl7", 0, 1, 4'd7, 0, 0);
        for (int i = 0; i < 4; i++) begin send(bv); bv++; end
        tick();
        check_flags("lvl8", 0, 1, 4'd8, 0, 0);
        for (int i = 0; i < 32; i++) begin send(bv); bv++; end
        tick();
        check_flags("ovf", 0, 1, 4'd8, 1, 0);
        check("ovf.head", word_o, 32'h04030201);
        clear_i = 1'b1;
        tick();
        clear_i = 1'b0;
        check_flags("ovf_clear", 0, 1, 4'd8, 0, 0);
        for (int i = 0; i < 4; i++) begin send(bv); bv++; end
        word_ready_i = 1'b1;
        tick();
        word_ready_i = 1'b0;
        check_flags("pushpop_full", 0, 1, 4'd8, 0, 0);
        check("pushpop_full.head", word_o, 32'h08070605);

        // Stuck source: 16 identical bytes trip the health test and flush.
        for (int i = 0; i < 16; i++) send(8'hA5);
        check_flags("trip", 0, 0, 4'd0, 1, 1);
        send(8'h01);
        send(8'h02);
        check_flags("fail_ignore", 0, 0, 4'd0, 1, 1);
        clear_i = 1'b1;
        tick();
        clear_i = 1'b0;
        check_flags("fail_clear", 0, 0, 4'd0, 0, 0);
        tick();
        check_flags("restart", 1, 0, 4'd0, 0, 0);

        // Reset mid-word with words buffered.
        for (int i = 0; i < 12; i++) send(8'(8'h10 + i));
        tick();
        check("pre_rst.level", 32'(fifo_level_o), 32'd3);
        send(8'h1C);
        send(8'h1D);
        rst = 1'b0;
        tick();
        check_flags("mid_rst", 0, 0, 4'd0, 0, 0);
        rst = 1'b1;
        tick();
        check("post_rst.enable", 32'(rng_enable_o), 32'd1);
        send(8'hC1);
        send(8'hC2);
        send(8'hC3);
        send(8'hC4);
        tick();
        check_flags("post_rst", 1, 1, 4'd1, 0, 0);
        check("post_rst.word", word_o, 32'hC4C3C2C1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
